// File: rtl/inv_addkey_mix.sv
// ---------------------------------------------------------------------------
// inv_addkey_mix
//   AES-128 decryption round tail: AddRoundKey followed by InvMixColumns.
//   The state that arrives from the inverse S-box stage is XORed with the
//   round key. For rounds 1..9 InvMixColumns is then applied. Round 0 (the
//   final round) and illegal rounds (>9) pass the XOR result through unmixed.
//   An illegal round also sets a sticky error flag that only reset clears.
//
//   Configuration macro: INV_ADDKEY_MIX_PIPE_EN
//     undefined : one output register stage, latency 1
//     defined   : stage 1 holds X and the round, stage 2 holds the mixed
//                 result, latency 2
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   s_valid  input state valid
//   s_ready  this block accepts the input this cycle
//   s_state  inverse S-box output, byte k at [127-8k -: 8]
//   s_key    round key, same byte order
//   s_round  decryption round index (9 down to 0)
//   m_valid  result valid
//   m_ready  downstream accepts the result
//   m_state  result state
//   m_round  round index carried with the data
//   m_last   result is the plaintext (round 0)
//   err      sticky illegal-round flag
// ---------------------------------------------------------------------------
module inv_addkey_mix (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_state,
  input  logic [127:0] s_key,
  input  logic [3:0]   s_round,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_state,
  output logic [3:0]   m_round,
  output logic         m_last,
  output logic         err
);

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (09, 0B, 0D, 0E are the only ones used).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2   = xtime(b);
    b4   = xtime(b2);
    b8   = xtime(b4);
    gmul = (c[0] ? b  : 8'h00) ^ (c[1] ? b2 : 8'h00) ^
           (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
  endfunction

  // One column; the top byte is row 0.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    inv_mix_col = {
      gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
      gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
      gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
      gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)
    };
  endfunction

  // Only rounds 1..9 are mixed; round 0 and illegal rounds pass X through.
  function automatic logic [127:0] round_result(input logic [127:0] x,
                                                input logic [3:0]   rnd);
    logic [127:0] r;
    r = x;
    if ((rnd >= 4'd1) && (rnd <= 4'd9)) begin
      for (int c = 0; c < 4; c++) begin
        r[127-32*c -: 32] = inv_mix_col(x[127-32*c -: 32]);
      end
    end else begin
      r = x;
    end
    round_result = r;
  endfunction

  logic [127:0] x_s;
  logic         accept_s;
  logic         illegal_s;

  logic         m_valid_r;
  logic [127:0] m_state_r;
  logic [3:0]   m_round_r;
  logic         m_last_r;
  logic         err_r;

  assign x_s       = s_state ^ s_key;
  assign accept_s  = s_valid && s_ready;
  assign illegal_s = (s_round > 4'd9);

`ifdef INV_ADDKEY_MIX_PIPE_EN
  logic         s1_valid_r;
  logic [127:0] s1_x_r;
  logic [3:0]   s1_round_r;
  logic         adv_s;

  // Stage 2 can take new data when empty or being drained this cycle.
  assign adv_s   = !m_valid_r || m_ready;
  assign s_ready = !s1_valid_r || adv_s;

  // Stage 1: capture X and round on accept; empty when handed to stage 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_x_r     <= 128'd0;
      s1_round_r <= 4'd0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_x_r     <= x_s;
      s1_round_r <= s_round;
    end else if (adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2 / output register: mix the stage-1 contents and hold on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_state_r <= 128'd0;
      m_round_r <= 4'd0;
      m_last_r  <= 1'b0;
    end else if (s1_valid_r && adv_s) begin
      m_valid_r <= 1'b1;
      m_state_r <= round_result(s1_x_r, s1_round_r);
      m_round_r <= s1_round_r;
      m_last_r  <= (s1_round_r == 4'd0);
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end
`else
  // Accept whenever the output register is empty or draining this cycle.
  assign s_ready = !m_valid_r || m_ready;

  // Output register: load the result on accept, hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_state_r <= 128'd0;
      m_round_r <= 4'd0;
      m_last_r  <= 1'b0;
    end else if (accept_s) begin
      m_valid_r <= 1'b1;
      m_state_r <= round_result(x_s, s_round);
      m_round_r <= s_round;
      m_last_r  <= (s_round == 4'd0);
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end
`endif

  // Sticky error: set when an illegal round is accepted, cleared by reset only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (accept_s && illegal_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign m_valid = m_valid_r;
  assign m_state = m_state_r;
  assign m_round = m_round_r;
  assign m_last  = m_last_r;
  assign err     = err_r;

endmodule

// File: tb/tb_inv_addkey_mix.sv
// ---------------------------------------------------------------------------
// tb_inv_addkey_mix
//   Directed self-checking bench for inv_addkey_mix. Inputs are driven 1 time
//   unit after the rising edge, outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_inv_addkey_mix;

`ifdef INV_ADDKEY_MIX_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_state;
  logic [127:0] s_key;
  logic [3:0]   s_round;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_state;
  logic [3:0]   m_round;
  logic         m_last;
  logic         err;

  int total_cnt = 0;
  int fail_cnt  = 0;

  inv_addkey_mix dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_state (s_state),
    .s_key   (s_key),
    .s_round (s_round),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_state (m_state),
    .m_round (m_round),
    .m_last  (m_last),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Send one state with m_ready=1, check latency and result, then drain.
  task automatic send_chk(input string tag, input logic [127:0] st, input logic [127:0] key,
                          input logic [3:0] rnd, input logic [127:0] exp_st, input logic exp_last);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_state = st;
    s_key   = key;
    s_round = rnd;
    #1;
    chk({tag, "_s_ready"}, 128'(s_ready), 128'(1'b1));
    step();
    s_valid = 1'b0;
    s_state = '1;
    s_key   = '0;
    for (int i = 1; i < LAT; i++) begin
      chk({tag, "_early_valid"}, 128'(m_valid), 128'(1'b0));
      step();
    end
    chk({tag, "_m_valid"}, 128'(m_valid), 128'(1'b1));
    chk({tag, "_m_state"}, m_state, exp_st);
    chk({tag, "_m_round"}, 128'(m_round), 128'(rnd));
    chk({tag, "_m_last"},  128'(m_last), 128'(exp_last));
    step();
    chk({tag, "_drained"}, 128'(m_valid), 128'(1'b0));
  endtask

  logic [127:0] bp_vec [4];
  logic [127:0] bp_key;
  logic [127:0] prev_state;
  logic         prev_stall;
  logic         acc;
  logic         emit;
  logic [127:0] emit_state;
  int           sent;
  int           recv;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_state = 128'd0;
    s_key   = 128'd0;
    s_round = 4'd0;
    m_ready = 1'b0;
    step();
    step();
    chk("rst_m_valid", 128'(m_valid), 128'(1'b0));
    chk("rst_m_state", m_state, 128'd0);
    chk("rst_m_round", 128'(m_round), 128'd0);
    chk("rst_m_last",  128'(m_last), 128'(1'b0));
    chk("rst_err",     128'(err), 128'(1'b0));
    rst_n = 1'b1;
    #1;
    chk("rst_s_ready", 128'(s_ready), 128'(1'b1));

    // Known InvMixColumns vector.
    send_chk("mix", {4{32'h8e4da1bc}}, 128'd0, 4'd5, {4{32'hdb135345}}, 1'b0);
    // Final round: FF ^ 0F = F0, no mixing.
    send_chk("final", {16{8'hff}}, {16{8'h0f}}, 4'd0, {16{8'hf0}}, 1'b1);
    // Columns of equal bytes are fixed points of InvMixColumns.
    send_chk("fixed", {32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6, 32'h01010101}, 128'd0, 4'd3,
             {32'hc6c6c6c6, 32'h01010101, 32'hc6c6c6c6, 32'h01010101}, 1'b0);
    chk("err_still_0", 128'(err), 128'(1'b0));

    // Backpressure: 4 round-0 states, m_ready low for the first 3 cycles.
    bp_key    = 128'h0f0e0d0c0b0a09080706050403020100;
    bp_vec[0] = 128'h00112233445566778899aabbccddeeff;
    bp_vec[1] = 128'h11111111222222223333333344444444;
    bp_vec[2] = 128'hdeadbeefcafef00d0123456789abcdef;
    bp_vec[3] = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
    sent       = 0;
    recv       = 0;
    prev_stall = 1'b0;
    prev_state = 128'd0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      m_ready = (cyc >= 3);
      s_valid = (sent < 4);
      s_state = (sent < 4) ? bp_vec[sent] : 128'd0;
      s_key   = bp_key;
      s_round = 4'd0;
      #1;
      if (cyc == 2) chk("bp_s_ready_full", 128'(s_ready), 128'(1'b0));
      if (prev_stall) chk("bp_stable", m_state, prev_state);
      acc        = s_valid && s_ready;
      emit       = m_valid && m_ready;
      emit_state = m_state;
      prev_stall = m_valid && !m_ready;
      prev_state = m_state;
      if (emit) begin
        if (recv < 4) begin
          chk("bp_order", emit_state, bp_vec[recv] ^ bp_key);
        end else begin
          chk("bp_dup", 128'(recv), 128'd3);
        end
        recv++;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    s_valid = 1'b0;
    chk("bp_recv_count", 128'(recv), 128'd4);
    step();

    // Illegal round: unmixed pass-through and sticky err.
    send_chk("illegal", {4{32'h8e4da1bc}}, 128'd0, 4'd12, {4{32'h8e4da1bc}}, 1'b0);
    chk("err_set", 128'(err), 128'(1'b1));
    send_chk("legal_after", {4{32'h8e4da1bc}}, 128'd0, 4'd5, {4{32'hdb135345}}, 1'b0);
    chk("err_sticky", 128'(err), 128'(1'b1));

    // Reset while a result is stalled; a handshake in the reset cycle is ignored.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_state = {16{8'h5a}};
    s_key   = 128'd0;
    s_round = 4'd0;
    step();
    s_valid = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    chk("mid_m_valid", 128'(m_valid), 128'(1'b1));
    rst_n   = 1'b0;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    rst_n   = 1'b1;
    chk("mrst_m_valid", 128'(m_valid), 128'(1'b0));
    chk("mrst_m_state", m_state, 128'd0);
    chk("mrst_m_round", 128'(m_round), 128'd0);
    chk("mrst_m_last",  128'(m_last), 128'(1'b0));
    chk("mrst_err",     128'(err), 128'(1'b0));
    chk("mrst_s_ready", 128'(s_ready), 128'(1'b1));
    m_ready = 1'b1;
    for (int i = 0; i < LAT; i++) step();
    chk("mrst_no_ghost", 128'(m_valid), 128'(1'b0));

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inv_addkey_mix.md
INV_ADDKEY_MIX -- requirements
Module: inv_addkey_mix

Interface
REQ-001 SHALL have one clock and one reset; the reset is synchronous and active-low.
REQ-002 SHALL have no parameters; all widths are fixed for AES-128.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 s_valid  input  1  the upstream inverse S-box stage presents a state.
REQ-006 s_ready  output  1  this block accepts the presented state this cycle.
REQ-007 s_state  input  128  output of the inverse S-box stage; byte k is at [127-8k -: 8]; column c is bytes 4c..4c+3, with byte 4c as row 0.
REQ-008 s_key  input  128  round key, same byte order, sampled with s_state.
REQ-009 s_round  input  4  decryption round index, 9 down to 0.
REQ-010 m_valid  output  1  result available.
REQ-011 m_ready  input  1  downstream accepts the result.
REQ-012 m_state  output  128  result state.
REQ-013 m_round  output  4  s_round carried with the data.
REQ-014 m_last  output  1  high when m_round==0 (plaintext is on m_state).
REQ-015 err  output  1  sticky flag for an illegal round index.

Function
REQ-016 SHALL accept an input on a cycle where s_valid && s_ready, and emit an output on a cycle where m_valid && m_ready.
REQ-017 SHALL compute X = s_state XOR s_key.
REQ-018 When round 1..9, SHALL set m_state = InvMixColumns(X), applied per column with matrix rows {0E,0B,0D,09} rotated, over GF(2^8) with polynomial 0x11B.
REQ-019 When round==0, SHALL set m_state = X and m_last=1; no InvMixColumns is applied.
REQ-020 When s_round > 9, SHALL still accept the input, set err=1 (held until reset), and pass X through unmixed with m_last=0.
REQ-021 SHALL use a single output register stage: latency 1 cycle from accept to m_valid (without macro).
REQ-022 SHALL drive s_ready = !m_valid || m_ready for full throughput; accept and emit can occur in the same cycle.
REQ-023 SHALL hold m_state, m_round and m_last stable while m_valid && !m_ready.
REQ-024 SHALL never deassert m_valid without a handshake.
REQ-025 SHALL not depend on s_state/s_key values when s_valid=0.

Reset
REQ-026 When rst_n=0 at a clock edge, SHALL clear m_valid=0, m_state=0, m_round=0, m_last=0 and err=0.
REQ-027 SHALL drop any data in flight on reset, with no output emitted for it.
REQ-028 SHALL drive s_ready=1 in the first cycle after reset.
REQ-029 A handshake attempted in a reset cycle SHALL be ignored.

Configuration
REQ-030 Macro INV_ADDKEY_MIX_PIPE_EN selects the pipeline depth.
REQ-031 With INV_ADDKEY_MIX_PIPE_EN defined, SHALL register X plus round in stage 1 and the mixed result in stage 2, giving 2-cycle latency.
REQ-032 With the macro defined, SHALL use s_ready = !stage1_valid || stage2_can_advance; stage 2 behaves per REQ-022/023.
REQ-033 With the macro defined, SHALL sustain full throughput with no bubbles while m_ready=1.
REQ-034 With the macro defined, SHALL hold both stages on backpressure with no data loss.
REQ-035 With the macro defined, SHALL clear both valids on reset.
REQ-036 Without the macro, behaviour is exactly REQ-021/022.
REQ-037 Functional results SHALL be identical in both builds.

Verification
REQ-038 SHALL check mix: each column 8E4DA1BC, key 0, round 5, m_ready=1 -> each column DB135345, m_last=0, output 1 cycle after accept (2 with macro).
REQ-039 SHALL check final round: s_state all FF, s_key all 0F, round 0 -> m_state all F0, m_last=1, m_round=0.
REQ-040 SHALL check fixed points: columns C6C6C6C6 and 01010101, key 0, round 3 -> output unchanged.
REQ-041 SHALL check backpressure: stream 4 states with m_ready=0 for 3 cycles -> s_ready low once full, outputs stable, all 4 emitted in order with no loss or duplication.
REQ-042 SHALL check illegal round: s_round=12 -> X passed unmixed, err=1, err stays 1 across later legal inputs until rst_n=0.
REQ-043 SHALL check reset mid-operation: rst_n=0 while m_valid=1 and m_ready=0 -> next cycle m_valid=0, all outputs 0, s_ready=1.
